pipeline_hazard_ctrl: RTL and testbench

//  Central stage-control sequencer for the 5-stage pipeline. Each cycle it drives one CTRL_STATE code
//  (`CTRL_STATE_Default / _Stalled / _Bubble from defines.v) to the PC register and to IF_ID, ID_EX,
//  EX_MEM and MEM_WB. Handles: post-reset flush, MEM-stage memory wait with watchdog, EX branch redirect,
//  and load-use hazards. Also keeps a saturating stall-cycle counter.

---
 rtl/pipeline_hazard_ctrl_if.sv | 60 ++++++
 rtl/pipeline_hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Shared stage-control encoding and the hazard-controller port bundle.
// Inputs come from ID/EX/MEM; outputs steer PC and the four pipeline registers.
package pipeline_hazard_pkg;
    localparam int REG_AW = 5;
    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [1:0] ctrl_t;
    localparam ctrl_t CTRL_DEFAULT = 2'b00;
    localparam ctrl_t CTRL_STALLED = 2'b01;
    localparam ctrl_t CTRL_BUBBLE  = 2'b10;
    typedef struct packed {
        ctrl_t pc;
        ctrl_t if_id;
        ctrl_t id_ex;
        ctrl_t ex_mem;
        ctrl_t mem_wb;
    } ctrl_bundle_t;
endpackage

interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    import pipeline_hazard_pkg::*;

    reg_addr_t          id_rs1_addr_i;
    reg_addr_t          id_rs2_addr_i;
    logic               id_use_rs1_i;
    logic               id_use_rs2_i;
    reg_addr_t          ex_rd_addr_i;
    logic               ex_is_load_i;
    logic               ex_redirect_i;
    logic               mem_req_i;
    logic               mem_ready_i;
    ctrl_t              pc_ctrl_o;
    ctrl_t              if_id_ctrl_o;
    ctrl_t              id_ex_ctrl_o;
    ctrl_t              ex_mem_ctrl_o;
    ctrl_t              mem_wb_ctrl_o;
    logic               mem_timeout_o;
    logic [CNT_W-1:0]   stall_cnt_o;

    modport master (
        output id_rs1_addr_i, id_rs2_addr_i,
        output id_use_rs1_i, id_use_rs2_i,
        output ex_rd_addr_i, ex_is_load_i,
        output ex_redirect_i, mem_req_i, mem_ready_i,
        input  pc_ctrl_o, if_id_ctrl_o, id_ex_ctrl_o,
        input  ex_mem_ctrl_o, mem_wb_ctrl_o,
        input  mem_timeout_o, stall_cnt_o
    );

    modport slave (
        input  id_rs1_addr_i, id_rs2_addr_i,
        input  id_use_rs1_i, id_use_rs2_i,
        input  ex_rd_addr_i, ex_is_load_i,
        input  ex_redirect_i, mem_req_i, mem_ready_i,
        output pc_ctrl_o, if_id_ctrl_o, id_ex_ctrl_o,
        output ex_mem_ctrl_o, mem_wb_ctrl_o,
        output mem_timeout_o, stall_cnt_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stage-control sequencer: post-reset flush, MEM wait with watchdog,
// branch redirect and load-use interlock, plus a saturating stall counter.
module pipeline_hazard_ctrl
    import pipeline_hazard_pkg::*;
#(
    parameter int FLUSH_CYCLES = 4,
    parameter int TIMEOUT      = 255,
    parameter int CNT_W        = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  hz
);

    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam ctrl_bundle_t P_ALL_DEF = {
        CTRL_DEFAULT, CTRL_DEFAULT, CTRL_DEFAULT,
        CTRL_DEFAULT, CTRL_DEFAULT
    };
    localparam ctrl_bundle_t P_FLUSH = {
        CTRL_STALLED, CTRL_BUBBLE, CTRL_BUBBLE,
        CTRL_BUBBLE, CTRL_BUBBLE
    };
    localparam ctrl_bundle_t P_MEM = {
        CTRL_STALLED, CTRL_STALLED, CTRL_STALLED,
        CTRL_STALLED, CTRL_BUBBLE
    };
    localparam ctrl_bundle_t P_REDIR = {
        CTRL_DEFAULT, CTRL_BUBBLE, CTRL_BUBBLE,
        CTRL_DEFAULT, CTRL_DEFAULT
    };
    localparam ctrl_bundle_t P_LDUSE = {
        CTRL_STALLED, CTRL_STALLED, CTRL_BUBBLE,
        CTRL_DEFAULT, CTRL_DEFAULT
    };
    localparam ctrl_bundle_t P_HALT = {
        CTRL_STALLED, CTRL_STALLED, CTRL_STALLED,
        CTRL_STALLED, CTRL_STALLED
    };

    typedef enum logic [1:0] {
        S_FLUSH,
        S_RUN,
        S_MEM_WAIT,
        S_HALT
    } state_e;

    state_e           state_q, state_d;
    logic [FW-1:0]    flush_cnt_q, flush_cnt_d;
    logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic         load_use;
    logic         mem_stall;
    ctrl_bundle_t hzd_ctrl;
    ctrl_bundle_t ctrl;

    // rd==x0 never creates a dependency since x0 is hardwired
    always_comb begin
        load_use = hz.ex_is_load_i
                && (hz.ex_rd_addr_i != '0)
                && ((hz.id_use_rs1_i
                     && hz.id_rs1_addr_i == hz.ex_rd_addr_i)
                 || (hz.id_use_rs2_i
                     && hz.id_rs2_addr_i == hz.ex_rd_addr_i));
        mem_stall = hz.mem_req_i && !hz.mem_ready_i;
    end

    always_comb begin
        hzd_ctrl = P_ALL_DEF;
        priority case (1'b1)
            hz.ex_redirect_i: hzd_ctrl = P_REDIR;
            load_use:         hzd_ctrl = P_LDUSE;
            default:          hzd_ctrl = P_ALL_DEF;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
        ctrl        = P_ALL_DEF;
        unique case (state_q)
            S_FLUSH: begin
                ctrl        = P_FLUSH;
                flush_cnt_d = flush_cnt_q + FW'(1);
                if (flush_cnt_q == FW'(FLUSH_CYCLES - 1)) begin
                    state_d     = S_RUN;
                    flush_cnt_d = '0;
                end
            end
            S_RUN: begin
                if (mem_stall) begin
                    ctrl       = P_MEM;
                    state_d    = S_MEM_WAIT;
                    wait_cnt_d = WW'(1);
                end else begin
                    ctrl = hzd_ctrl;
                end
            end
            S_MEM_WAIT: begin
                // a ready response outranks the watchdog on the same cycle
                if (hz.mem_ready_i) begin
                    ctrl       = hzd_ctrl;
                    state_d    = S_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WW'(TIMEOUT)) begin
                    ctrl      = P_MEM;
                    state_d   = S_HALT;
                    timeout_d = 1'b1;
                end else begin
                    ctrl       = P_MEM;
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
            S_HALT: begin
                ctrl = P_HALT;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q != S_FLUSH
            && ctrl.pc == CTRL_STALLED
            && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_FLUSH;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.pc_ctrl_o     = ctrl.pc;
    assign hz.if_id_ctrl_o  = ctrl.if_id;
    assign hz.id_ex_ctrl_o  = ctrl.id_ex;
    assign hz.ex_mem_ctrl_o = ctrl.ex_mem;
    assign hz.mem_wb_ctrl_o = ctrl.mem_wb;
    assign hz.mem_timeout_o = timeout_q;
    assign hz.stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table, directed corner sequences
// and a randomized run against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_pkg::*;

    localparam int FLUSH = 4;
    localparam int TMO   = 8;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    localparam ctrl_t D = CTRL_DEFAULT;
    localparam ctrl_t S = CTRL_STALLED;
    localparam ctrl_t B = CTRL_BUBBLE;

    localparam ctrl_bundle_t E_DEF   = {D, D, D, D, D};
    localparam ctrl_bundle_t E_FLUSH = {S, B, B, B, B};
    localparam ctrl_bundle_t E_MEM   = {S, S, S, S, B};
    localparam ctrl_bundle_t E_REDIR = {D, B, B, D, D};
    localparam ctrl_bundle_t E_LDUSE = {S, S, B, D, D};
    localparam ctrl_bundle_t E_HALT  = {S, S, S, S, S};

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       u1;
        logic       u2;
        logic       ld;
        logic       redir;
        logic       req;
        logic       rdy;
    } in_t;

    typedef struct packed {
        in_t          in;
        ctrl_bundle_t exp;
    } vec_t;

    localparam in_t IDLE = '0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(CW)) hif ();

    pipeline_hazard_ctrl #(
        .FLUSH_CYCLES(FLUSH),
        .TIMEOUT(TMO),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz(hif.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // behavioural model state
    int m_flush, m_halt, m_wait, m_waited, m_to, m_stalls;

    function automatic ctrl_bundle_t act();
        return {hif.pc_ctrl_o, hif.if_id_ctrl_o, hif.id_ex_ctrl_o,
                hif.ex_mem_ctrl_o, hif.mem_wb_ctrl_o};
    endfunction

    task automatic chk_ctrl(string nm, ctrl_bundle_t e);
        n_chk++;
        if (act() === e) n_pass++;
        else $display("FAIL %s ctrl: got %h want %h", nm, act(), e);
    endtask

    task automatic chk_to(string nm, logic e);
        n_chk++;
        if (hif.mem_timeout_o === e) n_pass++;
        else $display("FAIL %s timeout: got %b want %b",
                      nm, hif.mem_timeout_o, e);
    endtask

    task automatic chk_cnt(string nm, int e);
        n_chk++;
        if (hif.stall_cnt_o === CW'(e)) n_pass++;
        else $display("FAIL %s stall_cnt: got %0d want %0d",
                      nm, hif.stall_cnt_o, e);
    endtask

    task automatic drive(in_t v);
        hif.id_rs1_addr_i = v.rs1;
        hif.id_rs2_addr_i = v.rs2;
        hif.ex_rd_addr_i  = v.rd;
        hif.id_use_rs1_i  = v.u1;
        hif.id_use_rs2_i  = v.u2;
        hif.ex_is_load_i  = v.ld;
        hif.ex_redirect_i = v.redir;
        hif.mem_req_i     = v.req;
        hif.mem_ready_i   = v.rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // async assert, check reset state, release, check the flush window
    task automatic do_reset(string nm);
        drive(IDLE);
        rst = 1'b0;
        #3;
        chk_ctrl({nm, "_rst"}, E_FLUSH);
        chk_to({nm, "_rst"}, 1'b0);
        chk_cnt({nm, "_rst"}, 0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < FLUSH; i++) begin
            #3;
            chk_ctrl($sformatf("%s_flush%0d", nm, i), E_FLUSH);
            tick();
        end
    endtask

    function automatic bit lu(in_t v);
        return v.ld && v.rd != 0
            && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
    endfunction

    function automatic ctrl_bundle_t m_hzd(in_t v);
        if (v.redir) return E_REDIR;
        if (lu(v)) return E_LDUSE;
        return E_DEF;
    endfunction

    task automatic m_reset();
        m_flush  = FLUSH;
        m_halt   = 0;
        m_wait   = 0;
        m_waited = 0;
        m_to     = 0;
        m_stalls = 0;
    endtask

    task automatic m_cycle(in_t v);
        ctrl_bundle_t e;
        int old_to, old_cnt;
        old_to  = m_to;
        old_cnt = (m_stalls > CMAX) ? CMAX : m_stalls;
        if (m_flush > 0) begin
            e = E_FLUSH;
            m_flush--;
        end else if (m_halt != 0) begin
            e = E_HALT;
        end else if (m_wait != 0 && v.rdy) begin
            e = m_hzd(v);
            m_wait = 0;
        end else if (m_wait != 0) begin
            e = E_MEM;
            if (m_waited == TMO) begin
                m_halt = 1;
                m_to   = 1;
                m_wait = 0;
            end else begin
                m_waited++;
            end
        end else if (v.req && !v.rdy) begin
            e = E_MEM;
            m_wait   = 1;
            m_waited = 1;
        end else begin
            e = m_hzd(v);
        end
        if (m_flush == 0 && e != E_FLUSH && e.pc == S) m_stalls++;
        drive(v);
        #3;
        chk_ctrl("rand", e);
        chk_to("rand", old_to[0]);
        chk_cnt("rand", old_cnt);
        tick();
    endtask

    vec_t tbl[8];
    in_t  v;
    int   exp_cnt;

    initial begin
        // rs1, rs2, rd, u1, u2, ld, redir, req, rdy
        tbl[0] = '{in: IDLE, exp: E_DEF};
        tbl[1] = '{in: {5'd1, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1,
                        1'b0, 1'b0, 1'b0}, exp: E_LDUSE};
        tbl[2] = '{in: {5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b1,
                        1'b0, 1'b0, 1'b0}, exp: E_LDUSE};
        tbl[3] = '{in: {5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1,
                        1'b0, 1'b0, 1'b0}, exp: E_DEF};
        tbl[4] = '{in: {5'd9, 5'd3, 5'd9, 1'b0, 1'b1, 1'b1,
                        1'b0, 1'b0, 1'b0}, exp: E_DEF};
        tbl[5] = '{in: {5'd1, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1,
                        1'b1, 1'b0, 1'b0}, exp: E_REDIR};
        tbl[6] = '{in: {5'd4, 5'd4, 5'd4, 1'b1, 1'b1, 1'b0,
                        1'b0, 1'b1, 1'b1}, exp: E_DEF};
        tbl[7] = '{in: {5'd4, 5'd6, 5'd4, 1'b1, 1'b0, 1'b1,
                        1'b0, 1'b1, 1'b1}, exp: E_LDUSE};

        // T1: reset and flush window, then normal flow
        do_reset("t1");
        drive(IDLE);
        #3;
        chk_ctrl("t1_run", E_DEF);
        chk_cnt("t1_run", 0);
        tick();

        // single-cycle RUN vectors (T2, T3 among them)
        exp_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].in);
            #3;
            chk_ctrl($sformatf("vec%0d", i), tbl[i].exp);
            chk_cnt($sformatf("vec%0d", i), exp_cnt);
            tick();
            if (tbl[i].exp.pc == S) exp_cnt++;
        end
        drive(IDLE);
        #3;
        chk_cnt("vec_end", exp_cnt);
        tick();

        // T4: memory wait with a redirect held throughout
        do_reset("t4");
        v = IDLE;
        v.redir = 1'b1;
        v.req   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(v);
            #3;
            chk_ctrl($sformatf("t4_wait%0d", i), E_MEM);
            chk_cnt($sformatf("t4_wait%0d", i), i);
            tick();
        end
        v.rdy = 1'b1;
        drive(v);
        #3;
        chk_ctrl("t4_ready", E_REDIR);
        chk_cnt("t4_ready", 4);
        tick();
        drive(IDLE);
        #3;
        chk_ctrl("t4_after", E_DEF);
        chk_cnt("t4_after", 4);
        chk_to("t4_after", 1'b0);
        tick();

        // T5: watchdog expiry and HALT
        do_reset("t5");
        v = IDLE;
        v.req = 1'b1;
        for (int i = 0; i < TMO + 1; i++) begin
            drive(v);
            #3;
            chk_ctrl($sformatf("t5_wait%0d", i), E_MEM);
            chk_to($sformatf("t5_wait%0d", i), 1'b0);
            tick();
        end
        v.rdy = 1'b1;
        drive(v);
        #3;
        chk_ctrl("t5_halt", E_HALT);
        chk_to("t5_halt", 1'b1);
        chk_cnt("t5_halt", TMO + 1);
        tick();
        #3;
        chk_ctrl("t5_halt2", E_HALT);
        chk_cnt("t5_halt2", TMO + 2);
        tick();
        rst = 1'b0;
        #1;
        chk_to("t5_clear", 1'b0);
        chk_cnt("t5_clear", 0);

        // T6: ready exactly on the watchdog cycle, then saturation
        do_reset("t6");
        v = IDLE;
        v.req = 1'b1;
        for (int i = 0; i < TMO; i++) begin
            drive(v);
            tick();
        end
        v.rdy = 1'b1;
        drive(v);
        #3;
        chk_ctrl("t6_edge", E_DEF);
        chk_to("t6_edge", 1'b0);
        tick();
        drive(IDLE);
        #3;
        chk_ctrl("t6_run", E_DEF);
        chk_to("t6_run", 1'b0);
        chk_cnt("t6_run", TMO);
        tick();
        drive(tbl[1].in);
        for (int i = 0; i < 12; i++) begin
            #3;
            chk_ctrl($sformatf("t6_sat%0d", i), E_LDUSE);
            chk_cnt($sformatf("t6_sat%0d", i),
                    (TMO + i > CMAX) ? CMAX : TMO + i);
            tick();
        end
        drive(IDLE);
        #3;
        chk_cnt("t6_hold", CMAX);
        tick();

        // randomized run against the model, occasional async reset
        drive(IDLE);
        rst = 1'b0;
        m_reset();
        tick();
        rst = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                rst = 1'b0;
                #1;
                chk_ctrl("rand_rst", E_FLUSH);
                chk_to("rand_rst", 1'b0);
                chk_cnt("rand_rst", 0);
                m_reset();
                tick();
                rst = 1'b1;
            end
            v.rs1   = 5'($urandom_range(0, 3));
            v.rs2   = 5'($urandom_range(0, 3));
            v.rd    = 5'($urandom_range(0, 3));
            v.u1    = 1'($urandom_range(0, 1));
            v.u2    = 1'($urandom_range(0, 1));
            v.ld    = 1'($urandom_range(0, 1));
            v.redir = ($urandom_range(0, 4) == 0);
            v.req   = ($urandom_range(0, 9) < 3);
            v.rdy   = ($urandom_range(0, 9) < 6);
            m_cycle(v);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
